mem_port_arbiter: RTL and testbench

Shares the single memory port between instruction fetch (I-side) and load/store (D-side) in the TISC core. It accepts one request at a time and latches the winner's address, write enable and write data. It drives the memory port for exactly one transaction and returns read data and completion to the owner. It also exports the select that steers the core's 32-bit address/data mux2 instances.

---
 rtl/tisc_pkg.sv | 16 +
 rtl/arb_pick.sv | 23 ++
 rtl/mux2.sv | 15 +
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/tisc_pkg.sv
// tisc_pkg: shared types and constants for the TISC memory-port arbiter.
`default_nettype none

package tisc_pkg;
   localparam int WORD_W = 32;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;
endpackage

`default_nettype wire

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select between I-side and D-side requests.
`default_nettype none

module arb_pick
   import tisc_pkg::*;
(
   input  logic       i_req_i,
   input  logic       d_req_i,
   input  logic       last_gnt_i,
   output logic [1:0] gnt_o,
   output logic       pick_o
);
   logic d_wins;

   // On a tie the side that did not own the last grant wins.
   assign d_wins = d_req_i && (!i_req_i || (last_gnt_i == OWNER_I));

   // gnt_o[1] = D-side, gnt_o[0] = I-side
   assign gnt_o  = {d_wins, i_req_i && !d_wins};
   assign pick_o = d_wins ? OWNER_D : OWNER_I;
endmodule

`default_nettype wire

// File: rtl/mux2.sv
// mux2: 32-bit two-input word mux used for address/data steering (sel=1 picks b_i).
`default_nettype none

module mux2
   import tisc_pkg::*;
(
   input  logic              sel_i,
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   output logic [WORD_W-1:0] y_o
);
   assign y_o = sel_i ? b_i : a_i;
endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one transaction at a time.
// Build option ARB_ROUND_ROBIN_EN: alternate winners on ties instead of fixed D-side priority.
`default_nettype none

module mem_port_arbiter
   import tisc_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [WORD_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [WORD_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic [WORD_W-1:0] d_addr,
   input  logic              d_we,
   input  logic [WORD_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [WORD_W-1:0] d_rdata,
   output logic              mem_req,
   output logic [WORD_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              owner_sel
);
   arb_state_e        state_q, state_d;
   logic              owner_q;
   logic              mem_we_q;
   logic [WORD_W-1:0] mem_addr_q, mem_wdata_q;
   logic              i_rvalid_q, d_rvalid_q;
   logic [WORD_W-1:0] i_rdata_q, d_rdata_q;

   logic              last_gnt;
   logic [1:0]        pick_gnt;
   logic              pick_d;
   logic              take;
   logic              done;
   logic [WORD_W-1:0] addr_sel, wdata_sel;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     last_q <= OWNER_D;
      else if (take) last_q <= pick_d;
   end

   assign last_gnt = last_q;
`else
   // Pretending the I-side always owned the last grant makes every tie go to D.
   assign last_gnt = OWNER_I;
`endif

   arb_pick u_pick (
      .i_req_i    (i_req),
      .d_req_i    (d_req),
      .last_gnt_i (last_gnt),
      .gnt_o      (pick_gnt),
      .pick_o     (pick_d)
   );

   mux2 u_addr_mux (
      .sel_i (pick_d),
      .a_i   (i_addr),
      .b_i   (d_addr),
      .y_o   (addr_sel)
   );

   mux2 u_wdata_mux (
      .sel_i (pick_d),
      .a_i   ('0),
      .b_i   (d_wdata),
      .y_o   (wdata_sel)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|pick_gnt) begin
               take    = 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q     <= OWNER_I;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         if (take) begin
            owner_q     <= pick_d;
            mem_addr_q  <= addr_sel;
            mem_wdata_q <= wdata_sel;
            mem_we_q    <= pick_d & d_we;
         end
         if (done) begin
            if (owner_q == OWNER_D) begin
               d_rvalid_q <= 1'b1;
               if (!mem_we_q) d_rdata_q <= mem_rdata;
            end else begin
               i_rvalid_q <= 1'b1;
               i_rdata_q  <= mem_rdata;
            end
         end
      end
   end

   // Grants are combinational, so they must be forced low while reset is held.
   assign i_gnt     = take & pick_gnt[0] & ~reset;
   assign d_gnt     = take & pick_gnt[1] & ~reset;
   assign mem_req   = (state_q == BUSY);
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign owner_sel = owner_q;
   assign i_rvalid  = i_rvalid_q;
   assign i_rdata   = i_rdata_q;
   assign d_rvalid  = d_rvalid_q;
   assign d_rdata   = d_rdata_q;
endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus corner sequences, completions checked against a scoreboard queue.
`default_nettype none

module tb_mem_port_arbiter;
   logic        clk, reset;
   logic        i_req, i_gnt, i_rvalid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_req, mem_we, mem_ready, owner_sel;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   mem_port_arbiter dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .owner_sel(owner_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic        side;
      logic [31:0] data;
   } sb_t;

   sb_t         sb[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] d_rdata_model = 32'h0;
   vec_t        vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic side, input logic [31:0] data);
      sb_t e;
      e.side = side;
      e.data = data;
      sb.push_back(e);
   endtask

   // Completion monitor: every rvalid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      sb_t e;
      if (i_rvalid || d_rvalid) begin
         if (i_rvalid && d_rvalid) chk("rvalid_both", 32'd1, 32'd0);
         if (sb.size() == 0) begin
            chk("rvalid_unexpected", {30'b0, i_rvalid, d_rvalid}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rvalid_side", {31'b0, d_rvalid}, {31'b0, e.side});
            chk("rdata", d_rvalid ? d_rdata : i_rdata, e.data);
         end
      end
   end

   // Entered at posedge+1 in IDLE; leaves at posedge+1 of the rvalid cycle.
   task automatic run_txn(input vec_t v);
      i_req = !v.d; d_req = v.d;
      if (v.d) begin d_addr = v.addr; d_we = v.we; d_wdata = v.wdata; end
      else     i_addr = v.addr;
      @(negedge clk);
      chk("gnt_i", {31'b0, i_gnt}, {31'b0, !v.d});
      chk("gnt_d", {31'b0, d_gnt}, {31'b0, v.d});
      if (v.d && v.we) push(1'b1, d_rdata_model);
      else begin
         push(v.d, v.rdata);
         if (v.d) d_rdata_model = v.rdata;
      end
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
      i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_we = 1'b0;
      for (int w = 0; w <= v.waits; w++) begin
         mem_ready = (w == v.waits);
         mem_rdata = (w == v.waits) ? v.rdata : $urandom;
         @(negedge clk);
         chk("busy_mem_req", {31'b0, mem_req}, 32'd1);
         chk("busy_mem_addr", mem_addr, v.addr);
         chk("busy_mem_we", {31'b0, mem_we}, {31'b0, v.d & v.we});
         if (v.d && v.we) chk("busy_mem_wdata", mem_wdata, v.wdata);
         chk("busy_owner", {31'b0, owner_sel}, {31'b0, v.d});
         chk("busy_no_gnt", {30'b0, i_gnt, d_gnt}, 32'd0);
         @(posedge clk); #1;
      end
      mem_ready = 1'b0; mem_rdata = $urandom;
      @(negedge clk);
      chk("rv_i_timing", {31'b0, i_rvalid}, {31'b0, !v.d});
      chk("rv_d_timing", {31'b0, d_rvalid}, {31'b0, v.d});
      chk("done_mem_req", {31'b0, mem_req}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic exp_side;
      vecs[0] = '{d: 1'b0, we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0, waits: 0, rdata: 32'hDEAD_BEEF};
      vecs[1] = '{d: 1'b1, we: 1'b1, addr: 32'h0000_0100, wdata: 32'h1234_5678, waits: 3, rdata: 32'h5555_AAAA};
      vecs[2] = '{d: 1'b1, we: 1'b0, addr: 32'h0000_0200, wdata: 32'h0, waits: 1, rdata: 32'hCAFE_F00D};
      vecs[3] = '{d: 1'b0, we: 1'b0, addr: 32'h0000_0044, wdata: 32'h0, waits: 2, rdata: 32'h0102_0304};
      vecs[4] = '{d: 1'b1, we: 1'b1, addr: 32'h0000_0204, wdata: 32'h9999_0000, waits: 0, rdata: 32'h7777_7777};

      reset = 1'b1; i_req = 1'b1; i_addr = 32'h40; d_req = 1'b0; d_addr = 0; d_we = 0; d_wdata = 0;
      mem_ready = 1'b0; mem_rdata = 0;
      #2;
      chk("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_owner", {31'b0, owner_sel}, 32'd0);
      chk("rst_rdata", i_rdata | d_rdata, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0; i_req = 1'b0;

      for (int k = 0; k < 5; k++) run_txn(vecs[k]);

      // Fetch request raised during a D transaction and dropped before it could win.
      d_req = 1'b1; d_addr = 32'h500; d_we = 1'b0;
      @(negedge clk);
      chk("drop_d_gnt", {31'b0, d_gnt}, 32'd1);
      push(1'b1, 32'h0BAD_CAFE);
      d_rdata_model = 32'h0BAD_CAFE;
      @(posedge clk); #1;
      d_req = 1'b0; i_req = 1'b1; i_addr = 32'h600;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("drop_no_i_gnt", {31'b0, i_gnt}, 32'd0);
         @(posedge clk); #1;
         if (k == 0) i_req = 1'b0;
         if (k == 1) begin mem_ready = 1'b1; mem_rdata = 32'h0BAD_CAFE; end
         if (k == 2) mem_ready = 1'b0;
      end

      // Reset in the middle of a BUSY transaction.
      d_req = 1'b1; d_addr = 32'h300; d_we = 1'b1; d_wdata = 32'hFFFF_0001;
      @(negedge clk);
      chk("mid_d_gnt", {31'b0, d_gnt}, 32'd1);
      @(posedge clk); #1;
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk("mid_busy", {31'b0, mem_req}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("mid_rst_addr", mem_addr, 32'd0);
      chk("mid_rst_wdata", mem_wdata, 32'd0);
      chk("mid_rst_owner", {31'b0, owner_sel}, 32'd0);
      chk("mid_rst_d_rdata", d_rdata, 32'd0);
      d_rdata_model = 32'h0;
      @(posedge clk); #1;
      reset = 1'b0;
      mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("idle_ready_no_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
         chk("idle_ready_no_req", {31'b0, mem_req}, 32'd0);
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      run_txn('{d: 1'b1, we: 1'b0, addr: 32'h0000_0304, wdata: 32'h0, waits: 1, rdata: 32'h3333_4444});

      // Both sides requesting continuously with zero-wait memory.
      i_req = 1'b1; i_addr = 32'h700; d_req = 1'b1; d_addr = 32'h800; d_we = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) d_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         exp_side = (k == 4) ? 1'b0 : ((k % 2) == 1);
`else
         exp_side = (k != 4);
`endif
         @(negedge clk);
         chk("tie_gnt_i", {31'b0, i_gnt}, {31'b0, !exp_side});
         chk("tie_gnt_d", {31'b0, d_gnt}, {31'b0, exp_side});
         push(exp_side, 32'hA000_0000 + k);
         if (exp_side) d_rdata_model = 32'hA000_0000 + k;
         @(posedge clk); #1;
         if (k == 4) i_req = 1'b0;
         mem_ready = 1'b1; mem_rdata = 32'hA000_0000 + k;
         @(negedge clk);
         chk("tie_owner", {31'b0, owner_sel}, {31'b0, exp_side});
         chk("tie_addr", mem_addr, exp_side ? 32'h800 : 32'h700);
         chk("tie_mem_req", {31'b0, mem_req}, 32'd1);
         @(posedge clk); #1;
         mem_ready = 1'b0;
      end
      @(negedge clk);
      chk("tie_last_i_rvalid", {31'b0, i_rvalid}, 32'd1);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

`default_nettype wire
